// File: rtl/z_core_mul_ctrl.sv
// -----------------------------------------------------------------------------
// z_core_mul_ctrl
//
// Sequencer for the RISC-V M-extension multiply ops (MUL, MULH, MULHSU, MULHU)
// in the Z-Core execute stage. It captures one request, drives a combinational
// 32x32->64 multiplier that sits beside it, and holds the multiplier operands
// stable for LATENCY cycles so that the multiplier can be timed as a multicycle
// path. It then registers the selected 32-bit half of the product and returns
// it on a valid/ready response port.
//
// Optional build macro: Z_CORE_MUL_FUSE_EN
//   When defined, the block remembers the last product sampled from the
//   multiplier together with its operand/signedness key. A legal request with a
//   matching key completes in one edge from the stored product. An example is
//   MULHU followed by MUL on the same operands.
//
// Parameters
//   LATENCY        cycles the operands are held before the product is sampled
//                  (legal range 1..15)
//
// Ports
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   req_*          request: valid/ready, funct3, rs1/rs2 values, rd tag
//   flush          pipeline kill; abandons any in-flight op
//   rsp_*          response: valid/ready, result, rd tag, illegal flag
//   busy           high whenever the sequencer is not idle
//   mul_op1/2      registered operands to the external multiplier
//   mul_op*_signed registered operand signedness to the multiplier
//   mul_product    64-bit multiplier output
//   state_dbg      current FSM state (0 idle, 1 calc, 2 done) for checkers
//
// Handshake rules (both ports): a transfer happens on a rising edge where
// valid and ready are both high. A producer that has raised valid keeps it
// high, with stable payload, until that transfer. req_ready is high only in
// IDLE with no flush. rsp_valid stays high with stable rsp_result, rsp_rd and
// rsp_illegal until the consumer takes the response or a flush drops it.
// -----------------------------------------------------------------------------
module z_core_mul_ctrl #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [4:0]  req_rd,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_rd,
    output logic        rsp_illegal,
    output logic        busy,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    output logic        mul_op1_signed,
    output logic        mul_op2_signed,
    input  logic [63:0] mul_product,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter is loaded with LATENCY-1. The product is sampled on the edge
    // where the counter reads zero, which is LATENCY edges after acceptance.
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        valid_nxt;
    logic [31:0] result_nxt;
    logic        illegal_nxt;
    logic        hi_q;

    logic        accept;
    logic        dec_illegal;
    logic        dec_op1_s;
    logic        dec_op2_s;
    logic        dec_hi;

    logic        fuse_hit;
    logic [63:0] fuse_product;

    function automatic logic [31:0] pick_half(input logic [63:0] p, input logic hi);
        return hi ? p[63:32] : p[31:0];
    endfunction

    assign req_ready = (state == S_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // funct3 decode. MUL and MULHU use unsigned operands. MUL takes the low
    // half, because the low half does not depend on signedness.
    always_comb begin
        dec_illegal = req_funct3[2];
        dec_op1_s   = (req_funct3[1:0] == 2'b01) || (req_funct3[1:0] == 2'b10);
        dec_op2_s   = (req_funct3[1:0] == 2'b01);
        dec_hi      = (req_funct3[1:0] != 2'b00);
    end

`ifdef Z_CORE_MUL_FUSE_EN
    logic        fuse_valid;
    logic [65:0] fuse_key;
    logic [63:0] fuse_store;
    logic        fuse_wr;

    // Only a CALC completion that is not killed by flush writes the entry.
    assign fuse_wr = (state == S_CALC) && !flush && (cnt == 4'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fuse_valid <= 1'b0;
            fuse_key   <= '0;
            fuse_store <= '0;
        end else if (fuse_wr) begin
            fuse_valid <= 1'b1;
            fuse_key   <= {mul_op1, mul_op2, mul_op1_signed, mul_op2_signed};
            fuse_store <= mul_product;
        end
    end

    assign fuse_hit     = fuse_valid &&
                          (fuse_key == {req_op1, req_op2, dec_op1_s, dec_op2_s});
    assign fuse_product = fuse_store;
`else
    assign fuse_hit     = 1'b0;
    assign fuse_product = 64'd0;
`endif

    // State, counter and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            cnt         <= 4'd0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_illegal <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid   <= valid_nxt;
            rsp_result  <= result_nxt;
            rsp_illegal <= illegal_nxt;
        end
    end

    // Next state and response. flush has priority over counter expiry and
    // over the response handshake.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        valid_nxt   = rsp_valid;
        result_nxt  = rsp_result;
        illegal_nxt = rsp_illegal;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec_illegal) begin
                        state_nxt   = S_DONE;
                        valid_nxt   = 1'b1;
                        result_nxt  = 32'd0;
                        illegal_nxt = 1'b1;
                    end else if (fuse_hit) begin
                        state_nxt   = S_DONE;
                        valid_nxt   = 1'b1;
                        result_nxt  = pick_half(fuse_product, dec_hi);
                        illegal_nxt = 1'b0;
                    end else begin
                        state_nxt = S_CALC;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                    valid_nxt = 1'b0;
                end else if (cnt == 4'd0) begin
                    state_nxt   = S_DONE;
                    valid_nxt   = 1'b1;
                    result_nxt  = pick_half(mul_product, hi_q);
                    illegal_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (flush || rsp_ready) begin
                    state_nxt = S_IDLE;
                    valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Operand, signedness, half-select and tag registers. They load only on
    // acceptance. This keeps the multiplier inputs frozen for the whole of CALC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mul_op1        <= 32'd0;
            mul_op2        <= 32'd0;
            mul_op1_signed <= 1'b0;
            mul_op2_signed <= 1'b0;
            hi_q           <= 1'b0;
            rsp_rd         <= 5'd0;
        end else if (accept) begin
            mul_op1        <= req_op1;
            mul_op2        <= req_op2;
            mul_op1_signed <= dec_op1_s;
            mul_op2_signed <= dec_op2_s;
            hi_q           <= dec_hi;
            rsp_rd         <= req_rd;
        end
    end

endmodule

// File: tb/tb_z_core_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_z_core_mul_ctrl
//
// Self-checking bench for z_core_mul_ctrl. It models the external multiplier
// and runs three kinds of stimulus:
//   - a table of directed vectors
//   - hand-written sequences for stall, flush and asynchronous reset
//   - randomized ops checked against a reference model built from plain
//     integer arithmetic
// Latencies are counted as edges after the accepting edge: a legal op takes
// LATENCY, and an illegal op or a fused hit takes 0.
// -----------------------------------------------------------------------------
module tb_z_core_mul_ctrl;

    localparam int LATENCY = 2;
`ifdef Z_CORE_MUL_FUSE_EN
    localparam bit FUSE = 1'b1;
`else
    localparam bit FUSE = 1'b0;
`endif
    localparam int FUSE_LAT = FUSE ? 0 : LATENCY;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, flush, rsp_valid, rsp_ready, rsp_illegal, busy;
    logic [2:0]  req_funct3;
    logic [31:0] req_op1, req_op2, rsp_result, mul_op1, mul_op2;
    logic [4:0]  req_rd, rsp_rd;
    logic        mul_op1_signed, mul_op2_signed;
    logic [63:0] mul_product;
    logic [1:0]  state_dbg;

    z_core_mul_ctrl #(.LATENCY(LATENCY)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_op1(req_op1), .req_op2(req_op2), .req_rd(req_rd),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal), .busy(busy),
        .mul_op1(mul_op1), .mul_op2(mul_op2),
        .mul_op1_signed(mul_op1_signed), .mul_op2_signed(mul_op2_signed),
        .mul_product(mul_product), .state_dbg(state_dbg)
    );

    // External combinational multiplier: 66-bit extended operands.
    logic signed [65:0] mul_a, mul_b, mul_p;
    assign mul_a       = mul_op1_signed ? {{34{mul_op1[31]}}, mul_op1} : {34'd0, mul_op1};
    assign mul_b       = mul_op2_signed ? {{34{mul_op2[31]}}, mul_op2} : {34'd0, mul_op2};
    assign mul_p       = mul_a * mul_b;
    assign mul_product = mul_p[63:0];

    // ---------------- scoreboard / model ----------------
    logic [31:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference for the fused-result store: last completed legal op's key.
    bit          fz_valid = 1'b0;
    logic [31:0] fz_a, fz_b;
    bit          fz_s1, fz_s2;

    function automatic bit op_s1(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b010);   // MULH, MULHSU
    endfunction
    function automatic bit op_s2(input logic [2:0] f3);
        return (f3 == 3'b001);                     // MULH
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'(signed'(a));
        longint          sb = longint'(signed'(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     p;
        case (f3)
            3'b000:  begin p = ua * ub;                return p[31:0];  end
            3'b001:  begin p = sa * sb;                return p[63:32]; end
            3'b010:  begin p = sa * longint'(ub);      return p[63:32]; end
            3'b011:  begin p = ua * ub;                return p[63:32]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b);
        if (f3[2]) return 0;
        if (FUSE && fz_valid && fz_a == a && fz_b == b &&
            fz_s1 == op_s1(f3) && fz_s2 == op_s2(f3)) return 0;
        return LATENCY;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one op, measure latency, optionally stall the response, then take it.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input logic exp_ill,
                          input int exp_lat, input int stall);
        int w;
        int n;
        logic [31:0] exp_v;
        exp_q.push_back(exp_res);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_op1    = a;
        req_op2    = b;
        req_rd     = rd;
        #1;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check({tag, " req_ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(exp_lat));
        exp_v = exp_q.pop_front();
        check({tag, " result"}, rsp_result, exp_v);
        check({tag, " rd"}, 32'(rsp_rd), 32'(rd));
        check({tag, " illegal"}, 32'(rsp_illegal), 32'(exp_ill));
        for (int i = 0; i < stall; i++) begin
            tick();
            check({tag, " stall valid"}, 32'(rsp_valid), 32'd1);
            check({tag, " stall result"}, rsp_result, exp_v);
            check({tag, " stall rd"}, 32'(rsp_rd), 32'(rd));
            check({tag, " stall req_ready"}, 32'(req_ready), 32'd0);
            check({tag, " stall busy"}, 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        check({tag, " post valid"}, 32'(rsp_valid), 32'd0);
        check({tag, " post busy"}, 32'(busy), 32'd0);
        if (!f3[2]) begin
            fz_valid = 1'b1;
            fz_a     = a;
            fz_b     = b;
            fz_s1    = op_s1(f3);
            fz_s2    = op_s2(f3);
        end
    endtask

    // Accept an op and leave it in flight; the caller then kills it.
    task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_op1    = a;
        req_op2    = b;
        req_rd     = 5'd3;
        #1;
        check("start req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7,  32'hFFFF_FFFE, 1'b0, LATENCY};
        vecs[1]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0, LATENCY};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0, LATENCY};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, LATENCY};
        vecs[4]  = '{3'b100, 32'h1234_5678, 32'h0000_0009, 5'd4,  32'h0000_0000, 1'b1, 0};
        vecs[5]  = '{3'b111, 32'h0000_0001, 32'h0000_0001, 5'd31, 32'h0000_0000, 1'b1, 0};
        vecs[6]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 1'b0, LATENCY};
        vecs[7]  = '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'hC000_0000, 1'b0, LATENCY};
        vecs[8]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd8,  32'h2345_6780, 1'b0, LATENCY};
        vecs[9]  = '{3'b011, 32'h0001_0000, 32'h0003_0000, 5'd9,  32'h0000_0003, 1'b0, LATENCY};
        vecs[10] = '{3'b000, 32'h0001_0000, 32'h0003_0000, 5'd10, 32'h0000_0000, 1'b0, FUSE_LAT};
        vecs[11] = '{3'b001, 32'h0001_0000, 32'h0003_0000, 5'd11, 32'h0000_0003, 1'b0, LATENCY};

        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_funct3 = 3'd0;
        req_op1    = 32'd0;
        req_op2    = 32'd0;
        req_rd     = 5'd0;
        flush      = 1'b0;
        rsp_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("reset rsp_valid",   32'(rsp_valid), 32'd0);
        check("reset rsp_result",  rsp_result, 32'd0);
        check("reset rsp_rd",      32'(rsp_rd), 32'd0);
        check("reset rsp_illegal", 32'(rsp_illegal), 32'd0);
        check("reset mul_op1",     mul_op1, 32'd0);
        check("reset mul_op2",     mul_op2, 32'd0);
        check("reset signs",       32'({mul_op1_signed, mul_op2_signed}), 32'd0);
        check("reset busy",        32'(busy), 32'd0);
        check("reset req_ready",   32'(req_ready), 32'd1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Table-driven vectors
        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].res, vecs[i].ill, vecs[i].lat, 0);

        // Back-pressure: response held for 5 cycles with rsp_ready low
        run_op("stall", 3'b000, 32'd7, 32'd6, 5'd12, 32'd42, 1'b0,
               model_lat(3'b000, 32'd7, 32'd6), 5);

        // Flush on the counter-expiry edge: the op is dropped and not stored
        start_op(3'b000, 32'd3, 32'd5);
        tick();
        check("flush pre valid", 32'(rsp_valid), 32'd0);
        check("flush pre busy",  32'(busy), 32'd1);
        flush = 1'b1;
        #1;
        check("flush req_ready low", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush valid",     32'(rsp_valid), 32'd0);
        check("flush busy",      32'(busy), 32'd0);
        check("flush req_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush quiet valid", 32'(rsp_valid), 32'd0);
        end
        run_op("after_flush", 3'b000, 32'd3, 32'd5, 5'd13, 32'h0000_000F, 1'b0, LATENCY, 0);

        // Asynchronous reset mid-CALC: outputs clear with no clock edge
        start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        #2;
        rstn = 1'b0;
        #1;
        check("areset rsp_valid",   32'(rsp_valid), 32'd0);
        check("areset rsp_result",  rsp_result, 32'd0);
        check("areset rsp_rd",      32'(rsp_rd), 32'd0);
        check("areset mul_op1",     mul_op1, 32'd0);
        check("areset mul_op2",     mul_op2, 32'd0);
        check("areset busy",        32'(busy), 32'd0);
        fz_valid = 1'b0;
        tick();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("areset quiet valid", 32'(rsp_valid), 32'd0);
        end
        // Operands of the last completed op (after_flush) must not be reused
        run_op("after_reset", 3'b000, 32'd3, 32'd5, 5'd14, 32'h0000_000F, 1'b0, LATENCY, 0);

        // Randomized ops against the reference model
        begin
            logic [31:0] ra = 32'd1;
            logic [31:0] rb = 32'd1;
            logic [2:0]  rf;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 9) == 0) rf = 3'($urandom_range(4, 7));
                else                           rf = 3'($urandom_range(0, 3));
                if ($urandom_range(0, 9) >= 4) begin
                    case ($urandom_range(0, 3))
                        0:       ra = 32'h8000_0000;
                        1:       ra = 32'hFFFF_FFFF;
                        default: ra = $urandom;
                    endcase
                    rb = (($urandom_range(0, 3)) == 0) ? 32'h7FFF_FFFF : $urandom;
                end
                run_op($sformatf("rnd%0d", i), rf, ra, rb, 5'($urandom_range(0, 31)),
                       ref_result(rf, ra, rb), rf[2], model_lat(rf, ra, rb),
                       $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
